// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: accepts one word per valid/ready handshake and
// emits it one bit per clock with sof/last frame markers and an optional idle gap.
module piso_serializer #(
  parameter int WIDTH      = 4,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pin,
  input  logic             pin_valid,
  output logic             pin_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sof,
  output logic             last,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
  localparam logic [7:0]    GAP_LAST = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shreg, w_shreg_nxt, w_shifted;
  logic [CW-1:0]    r_bcnt, w_bcnt_nxt;
  logic [7:0]       r_gcnt, w_gcnt_nxt;
  logic             r_sout, r_valid, r_sof, r_last;
  logic             w_sout_nxt, w_valid_nxt, w_sof_nxt, w_last_nxt;
  logic             w_accept, w_bit_end, w_gap_end;
  logic             w_first_bit, w_next_bit;

  assign w_accept    = pin_valid && (r_state == S_IDLE);
  assign w_bit_end   = (r_bcnt == BIT_LAST);
  assign w_gap_end   = (r_gcnt == GAP_LAST);
  assign w_shifted   = MSB_FIRST ? (r_shreg << 1) : (r_shreg >> 1);
  assign w_first_bit = MSB_FIRST ? pin[WIDTH-1] : pin[0];
  assign w_next_bit  = MSB_FIRST ? w_shifted[WIDTH-1] : w_shifted[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_SHIFT;
      S_SHIFT: begin
        if (w_bit_end) begin
          if (GAP_CYCLES > 0) w_state_nxt = S_GAP;
          else                w_state_nxt = S_IDLE;
        end
      end
      S_GAP:   if (w_gap_end) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output registers are loaded with the bit that becomes visible after the
  // edge, so the shift register always holds the word aligned to the current bit.
  always_comb begin
    w_shreg_nxt = r_shreg;
    w_bcnt_nxt  = '0;
    w_gcnt_nxt  = '0;
    w_sout_nxt  = 1'b0;
    w_valid_nxt = 1'b0;
    w_sof_nxt   = 1'b0;
    w_last_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_shreg_nxt = pin;
          w_sout_nxt  = w_first_bit;
          w_valid_nxt = 1'b1;
          w_sof_nxt   = 1'b1;
          w_last_nxt  = (WIDTH == 1);
        end
      end
      S_SHIFT: begin
        if (!w_bit_end) begin
          w_shreg_nxt = w_shifted;
          w_bcnt_nxt  = r_bcnt + 1'b1;
          w_sout_nxt  = w_next_bit;
          w_valid_nxt = 1'b1;
          w_last_nxt  = ((r_bcnt + 1'b1) == BIT_LAST);
        end
      end
      S_GAP: begin
        if (!w_gap_end) w_gcnt_nxt = r_gcnt + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shreg <= '0;
      r_bcnt  <= '0;
      r_gcnt  <= '0;
      r_sout  <= 1'b0;
      r_valid <= 1'b0;
      r_sof   <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_shreg <= w_shreg_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_gcnt  <= w_gcnt_nxt;
      r_sout  <= w_sout_nxt;
      r_valid <= w_valid_nxt;
      r_sof   <= w_sof_nxt;
      r_last  <= w_last_nxt;
    end
  end

  assign pin_ready  = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign sout       = r_sout;
  assign sout_valid = r_valid;
  assign sof        = r_sof;
  assign last       = r_last;

endmodule
